// File: rtl/door_access_controller_if.sv
// door_access_controller_if: keypad input and display/indicator outputs of the door access controller
// Ports: master drives key_valid/key_code and observes outputs; slave is the controller side.
interface door_access_controller_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] d4, d3, d2, d1;
  logic       disp_sel;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;
  logic       unlock, deny, alarm;
  modport master (output key_valid, key_code,
                  input d4, d3, d2, d1, disp_sel, digit_cnt, fail_cnt, unlock, deny, alarm);
  modport slave  (input key_valid, key_code,
                  output d4, d3, d2, d1, disp_sel, digit_cnt, fail_cnt, unlock, deny, alarm);
endinterface

// File: rtl/door_access_controller.sv
// door_access_controller: passcode entry FSM driving unlock/deny/alarm and the entry display
// Ports: clk_i clock, rst_ni async active-low reset, bus (slave) keypad in, digits/status out.
module door_access_controller #(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          OPEN_CYCLES   = 50,
  parameter int          DENY_CYCLES   = 10,
  parameter int          LOCK_CYCLES   = 200,
  parameter int          ENTRY_TIMEOUT = 1000,
  parameter int          MAX_FAILS     = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  door_access_controller_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, DENY, LOCKOUT, PROG} state_t;
  state_t      state_q, state_d;
  logic [15:0] buf_q, buf_d, code_q, code_d, timer_q, timer_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d;
  logic        disp_q, unlock_q, deny_q, alarm_q;
  logic        is_digit, is_enter, is_clear, is_prog, key_acc, collecting;
  assign is_digit   = bus.key_valid && bus.key_code <= 4'd9;
  assign is_enter   = bus.key_valid && bus.key_code == 4'hA;
  assign is_clear   = bus.key_valid && bus.key_code == 4'hB;
  assign is_prog    = bus.key_valid && bus.key_code == 4'hC;
  assign key_acc    = bus.key_valid && bus.key_code <= 4'hB;
  assign collecting = state_q == ENTRY || state_q == PROG;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    code_d  = code_q;
    // IDLE holds an empty buffer, so appending there yields {0,0,0,key}
    if ((collecting || state_q == IDLE) && is_digit && cnt_q < 3'd4) begin
      buf_d = {buf_q[11:0], bus.key_code};
      cnt_d = cnt_q + 3'd1;
    end
    if (collecting && is_clear) begin
      buf_d = '0;
      cnt_d = '0;
    end
    unique case (state_q)
      IDLE:    state_d = is_digit ? ENTRY : IDLE;
      ENTRY:   state_d = is_enter ? CHECK : (!key_acc && timer_q == 16'(ENTRY_TIMEOUT - 1)) ? IDLE : ENTRY;
      CHECK: begin
        if (cnt_q == 3'd4 && buf_q == code_q) begin
          state_d = OPEN;
          fail_d  = '0;
        end else if (3'(fail_q) + 3'd1 == 3'(MAX_FAILS)) begin
          state_d = LOCKOUT;
        end else begin
          state_d = DENY;
          fail_d  = fail_q + 2'd1;
        end
      end
      OPEN:    state_d = is_prog ? PROG : timer_q == 16'(OPEN_CYCLES - 1) ? IDLE : OPEN;
      DENY:    state_d = timer_q == 16'(DENY_CYCLES - 1) ? IDLE : DENY;
      LOCKOUT: begin
        if (timer_q == 16'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
      PROG: begin
        if (is_enter) begin
          state_d = IDLE;
          code_d  = cnt_q == 3'd4 ? buf_q : code_q;
        end else if (!key_acc && timer_q == 16'(ENTRY_TIMEOUT - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // the buffer only survives while collecting or being checked
    if (!(state_d inside {ENTRY, PROG, CHECK})) begin
      buf_d = '0;
      cnt_d = '0;
    end
    timer_d = (state_d != state_q || (collecting && key_acc)) ? '0 : timer_q + 16'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      code_q   <= DEFAULT_CODE;
      timer_q  <= '0;
      disp_q   <= 1'b0;
      unlock_q <= 1'b0;
      deny_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      timer_q  <= timer_d;
      disp_q   <= state_d == ENTRY || state_d == PROG;
      unlock_q <= state_d == OPEN;
      deny_q   <= state_d == DENY;
      alarm_q  <= state_d == LOCKOUT;
    end
  end
  assign bus.d4        = buf_q[15:12];
  assign bus.d3        = buf_q[11:8];
  assign bus.d2        = buf_q[7:4];
  assign bus.d1        = buf_q[3:0];
  assign bus.digit_cnt = cnt_q;
  assign bus.fail_cnt  = fail_q;
  assign bus.disp_sel  = disp_q;
  assign bus.unlock    = unlock_q;
  assign bus.deny      = deny_q;
  assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_door_access_controller.sv
// tb_door_access_controller: scoreboard bench checking indicator pulses and entry buffer behaviour
module tb_door_access_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  door_access_controller_if dif();
  door_access_controller #(
    .DEFAULT_CODE(16'h1234), .OPEN_CYCLES(50), .DENY_CYCLES(10),
    .LOCK_CYCLES(200), .ENTRY_TIMEOUT(1000), .MAX_FAILS(3)
  ) dut (.clk_i(clk), .rst_ni(rst_n), .bus(dif));
  typedef struct {logic [2:0] kind; int len; logic [1:0] fail;} exp_t;
  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;
  logic [2:0] prev = '0;
  logic [2:0] cur;
  logic [1:0] start_fail = '0;
  int plen = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    else n_pass++;
  endtask
  task automatic expect_pulse(input logic [2:0] kind, input int len, input logic [1:0] fail);
    q.push_back(exp_t'{kind, len, fail});
  endtask
  // pulse monitor: kind is {alarm,deny,unlock}; a pulse is scored when it ends
  always @(negedge clk) begin
    cur = {dif.alarm, dif.deny, dif.unlock};
    if (!rst_n) begin
      prev = '0;
      plen = 0;
    end else begin
      if (cur != prev && prev != 3'b0) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL pulse_unexpected got kind=%b len=%0d", prev, plen);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.kind != prev || e.len != plen || e.fail != start_fail)
            $display("FAIL pulse got kind=%b len=%0d fail=%0d expected kind=%b len=%0d fail=%0d",
                     prev, plen, start_fail, e.kind, e.len, e.fail);
          else n_pass++;
        end
      end
      if (cur != prev) begin
        plen = 0;
        start_fail = dif.fail_cnt;
      end
      if (cur != 3'b0) plen++;
      prev = cur;
    end
  end
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    dif.key_valid = 1'b1;
    dif.key_code  = k;
    @(negedge clk);
    dif.key_valid = 1'b0;
    dif.key_code  = 4'h0;
  endtask
  task automatic code4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'hA);
  endtask
  task automatic drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (q.size() != 0) begin
      $display("FAIL %s timeout got pending=%0d expected pending=0", name, q.size());
      q.delete();
    end else n_pass++;
  endtask
  function automatic logic [15:0] dbuf();
    return {dif.d4, dif.d3, dif.d2, dif.d1};
  endfunction
  initial begin
    dif.key_valid = 1'b0;
    dif.key_code  = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_ind", {dif.unlock, dif.deny, dif.alarm, dif.disp_sel}, 0);
    chk("reset_buf", {dbuf(), dif.digit_cnt, dif.fail_cnt}, 0);
    rst_n = 1'b1;
    expect_pulse(3'b001, 50, 2'd0);
    for (int i = 1; i <= 4; i++) press(4'(i));
    chk("entry_buf", dbuf(), 16'h1234);
    chk("entry_cnt", dif.digit_cnt, 4);
    chk("entry_disp", dif.disp_sel, 1);
    press(4'hA);
    chk("check_cycle", {dif.unlock, dif.deny, dif.alarm, dif.disp_sel}, 0);
    drain("open1", 100);
    chk("open1_fail", dif.fail_cnt, 0);
    for (int i = 1; i <= 2; i++) begin
      expect_pulse(3'b010, 10, 2'(i));
      code4(16'h1235);
      drain("deny", 50);
      chk("deny_fail", dif.fail_cnt, i);
    end
    expect_pulse(3'b100, 200, 2'd2);
    code4(16'h1235);
    press(4'h1);
    press(4'h2);
    chk("lock_keys_ignored", dif.digit_cnt, 0);
    chk("lock_alarm", dif.alarm, 1);
    drain("lockout", 300);
    chk("lock_fail_clr", dif.fail_cnt, 0);
    expect_pulse(3'b010, 10, 2'd1);
    press(4'h1);
    press(4'h2);
    press(4'hA);
    drain("short_entry", 50);
    press(4'h9);
    for (int i = 1; i <= 5; i++) press(4'(i));
    chk("overflow_buf", dbuf(), 16'h9123);
    chk("overflow_cnt", dif.digit_cnt, 4);
    press(4'hB);
    chk("clear", {dbuf(), dif.digit_cnt, dif.disp_sel}, 1);
    press(4'h7);
    chk("timeout_start", dif.digit_cnt, 1);
    repeat (999) @(negedge clk);
    chk("timeout_before", dif.disp_sel, 1);
    @(negedge clk);
    chk("timeout_after", {dbuf(), dif.digit_cnt, dif.disp_sel}, 0);
    chk("timeout_fail", dif.fail_cnt, 1);
    expect_pulse(3'b001, 1, 2'd0);
    code4(16'h1234);
    press(4'hC);
    for (int i = 5; i <= 8; i++) press(4'(i));
    chk("prog_buf", dbuf(), 16'h5678);
    chk("prog_disp", dif.disp_sel, 1);
    press(4'hA);
    chk("prog_exit", {dbuf(), dif.digit_cnt, dif.disp_sel}, 0);
    drain("prog_open", 5);
    expect_pulse(3'b001, 50, 2'd0);
    code4(16'h5678);
    drain("new_code", 100);
    expect_pulse(3'b010, 10, 2'd1);
    code4(16'h1234);
    drain("old_code", 50);
    code4(16'h5678);
    repeat (3) @(negedge clk);
    chk("open_before_rst", dif.unlock, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_open", {dif.unlock, dif.deny, dif.alarm, dif.disp_sel, dbuf(), dif.digit_cnt, dif.fail_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_pulse(3'b001, 50, 2'd0);
    code4(16'h1234);
    drain("code_restored", 100);
    expect_pulse(3'b001, 1, 2'd0);
    code4(16'h1234);
    press(4'hC);
    press(4'h9);
    press(4'h9);
    chk("prog_partial", {dif.disp_sel, dif.digit_cnt}, {1'b1, 3'd2});
    drain("prog2_open", 5);
    #2 rst_n = 1'b0;
    #1 chk("rst_prog", {dif.unlock, dif.disp_sel, dbuf(), dif.digit_cnt, dif.fail_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_pulse(3'b001, 50, 2'd0);
    code4(16'h1234);
    drain("after_prog_rst", 100);
    expect_pulse(3'b010, 10, 2'd1);
    code4(16'h5678);
    drain("reprog_discarded", 50);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
